// File: rtl/fmul_axis.sv
// IEEE-754 binary32 multiplier behind joined A/B AXI-stream inputs.
// Three pipeline stages: unpack/classify, 24x24 multiply, normalize/round/pack.
module fmul_axis (
  input  logic        CLK,
  input  logic        INITIALIZE,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  output logic        s_axis_b_tready,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  input  logic        m_axis_result_tready,
  output logic [31:0] m_axis_result_tdata
);

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  // Handshake: a transfer happens on a rising edge where tvalid and tready are
  // both high. A and B only transfer together; the whole pipeline freezes while
  // the output holds a product the consumer has not taken.
  logic stall;
  logic accept;

  assign stall           = m_axis_result_tvalid & ~m_axis_result_tready;
  assign s_axis_a_tready = s_axis_b_tvalid & ~stall & ~INITIALIZE;
  assign s_axis_b_tready = s_axis_a_tvalid & ~stall & ~INITIALIZE;
  assign accept          = s_axis_a_tvalid & s_axis_b_tvalid & ~stall & ~INITIALIZE;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_sign_q, s1_sign_d;
  logic signed [9:0]  s1_exp_q, s1_exp_d;
  logic [23:0]        s1_ma_q, s1_ma_d;
  logic [23:0]        s1_mb_q, s1_mb_d;
  cls_t               s1_cls_q, s1_cls_d;

  logic               s2_valid_q, s2_valid_d;
  logic               s2_sign_q, s2_sign_d;
  logic signed [9:0]  s2_exp_q, s2_exp_d;
  logic [47:0]        s2_prod_q, s2_prod_d;
  cls_t               s2_cls_q, s2_cls_d;

  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;

  logic [7:0] a_exp, b_exp;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  always_comb begin
    a_exp  = s_axis_a_tdata[30:23];
    b_exp  = s_axis_b_tdata[30:23];
    a_nan  = (a_exp == 8'hFF) && (s_axis_a_tdata[22:0] != 23'd0);
    b_nan  = (b_exp == 8'hFF) && (s_axis_b_tdata[22:0] != 23'd0);
    a_inf  = (a_exp == 8'hFF) && (s_axis_a_tdata[22:0] == 23'd0);
    b_inf  = (b_exp == 8'hFF) && (s_axis_b_tdata[22:0] == 23'd0);
    // Denormals share the zero exponent and are flushed with true zeros.
    a_zero = (a_exp == 8'h00);
    b_zero = (b_exp == 8'h00);

    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_ma_d    = s1_ma_q;
    s1_mb_d    = s1_mb_q;
    s1_cls_d   = s1_cls_q;
    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_sign_d = s_axis_a_tdata[31] ^ s_axis_b_tdata[31];
        s1_exp_d  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;
        s1_ma_d   = {1'b1, s_axis_a_tdata[22:0]};
        s1_mb_d   = {1'b1, s_axis_b_tdata[22:0]};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
          s1_cls_d = CLS_NAN;
        else if (a_inf || b_inf)
          s1_cls_d = CLS_INF;
        else if (a_zero || b_zero)
          s1_cls_d = CLS_ZERO;
        else
          s1_cls_d = CLS_NORM;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_exp_d   = s2_exp_q;
    s2_prod_d  = s2_prod_q;
    s2_cls_d   = s2_cls_q;
    if (!stall) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d = s1_sign_q;
        s2_exp_d  = s1_exp_q;
        s2_prod_d = 48'(s1_ma_q) * 48'(s1_mb_q);
        s2_cls_d  = s1_cls_q;
      end
    end
  end

  logic [22:0]       mant;
  logic              guard, sticky, round_up;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_n;
  logic [31:0]       result;

  always_comb begin
    if (s2_prod_q[47]) begin
      mant   = s2_prod_q[46:24];
      guard  = s2_prod_q[23];
      sticky = |s2_prod_q[22:0];
      exp_n  = s2_exp_q + 10'sd1;
    end else begin
      mant   = s2_prod_q[45:23];
      guard  = s2_prod_q[22];
      sticky = |s2_prod_q[21:0];
      exp_n  = s2_exp_q;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    // A rounding carry leaves the fraction all zeros and bumps the exponent.
    if (mant_r[23]) exp_n = exp_n + 10'sd1;

    case (s2_cls_q)
      CLS_NAN:  result = 32'h7FC0_0000;
      CLS_INF:  result = {s2_sign_q, 8'hFF, 23'd0};
      CLS_ZERO: result = {s2_sign_q, 31'd0};
      default: begin
        if (exp_n >= 10'sd255)
          result = {s2_sign_q, 8'hFF, 23'd0};
        else if (exp_n <= 10'sd0)
          result = {s2_sign_q, 31'd0};
        else
          result = {s2_sign_q, exp_n[7:0], mant_r[22:0]};
      end
    endcase

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (!stall) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) out_data_d = result;
    end
  end

  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_ma_q     <= '0;
      s1_mb_q     <= '0;
      s1_cls_q    <= CLS_NORM;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_prod_q   <= '0;
      s2_cls_q    <= CLS_NORM;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_ma_q     <= s1_ma_d;
      s1_mb_q     <= s1_mb_d;
      s1_cls_q    <= s1_cls_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_exp_q    <= s2_exp_d;
      s2_prod_q   <= s2_prod_d;
      s2_cls_q    <= s2_cls_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign m_axis_result_tvalid = out_valid_q;
  assign m_axis_result_tdata  = out_data_q;

endmodule

// File: tb/tb_fmul_axis.sv
// Directed bench for fmul_axis: stimulus pushes hand-computed products into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_fmul_axis;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [31:0] a_data, b_data;
  logic        m_valid, m_ready;
  logic [31:0] m_data;

  fmul_axis dut (
    .CLK                  (clk),
    .INITIALIZE           (rst),
    .s_axis_a_tvalid      (a_valid),
    .s_axis_a_tready      (a_ready),
    .s_axis_a_tdata       (a_data),
    .s_axis_b_tvalid      (b_valid),
    .s_axis_b_tready      (b_ready),
    .s_axis_b_tdata       (b_data),
    .m_axis_result_tvalid (m_valid),
    .m_axis_result_tready (m_ready),
    .m_axis_result_tdata  (m_data)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rx  = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = 32'd0;

  // Directed vectors: a, b, expected a*b
  logic [31:0] va [0:15] = '{32'h40000000, 32'h3FC00000, 32'h3F800000, 32'h3F800001,
                             32'h7F800000, 32'h7F000000, 32'h00800000, 32'h80000001,
                             32'h7F800001, 32'hFF800000, 32'h80000000, 32'h3FC00000,
                             32'h3F800003, 32'h00800000, 32'h00800000, 32'h7F000000};
  logic [31:0] vb [0:15] = '{32'h40400000, 32'h3FC00000, 32'hBF800000, 32'h3F800001,
                             32'h00000000, 32'h40000000, 32'h00800000, 32'h3F800000,
                             32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F800001,
                             32'h3FC00000, 32'h3F800000, 32'h3F000000, 32'h3FFFFFFF};
  logic [31:0] ve [0:15] = '{32'h40C00000, 32'h40100000, 32'hBF800000, 32'h3F800002,
                             32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000,
                             32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h3FC00002,
                             32'h3FC00004, 32'h00800000, 32'h00000000, 32'h7F7FFFFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: pops on every output handshake and checks hold behaviour during stalls
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_tvalid", 32'(m_valid), 32'd1);
        check("hold_tdata", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        n_rx++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %h required no output", m_data);
        end else begin
          check("result", m_data, exp_q.pop_front());
        end
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
    end
  end

  // Driver tasks
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                      output int waited);
    waited  = 0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = a;
    b_data  = b;
    @(negedge clk);
    while (!(a_ready && b_ready) && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no tready required tready within 100 cycles");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic check_latency(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_valid && k < 20);
    check(name, 32'(k), 32'd3);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Main stimulus
  initial begin
    int w;
    int rx0;
    rst     = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 32'h3F800000;
    b_data  = 32'h3F800000;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(m_valid), 32'd0);
    check("rst_tdata", m_data, 32'h00000000);
    check("rst_a_tready", 32'(a_ready), 32'd0);
    check("rst_b_tready", 32'(b_ready), 32'd0);
    idle();
    @(posedge clk);
    #1 rst = 1'b0;

    // First pair in the first cycle after reset, then latency with an empty pipe
    send(va[0], vb[0], ve[0], w);
    check("first_cycle_accept", 32'(w), 32'd0);
    idle();
    check_latency("latency_basic");
    drain();

    // All directed vectors back-to-back with the consumer always ready
    for (int i = 0; i < 16; i++) begin
      send(va[i], vb[i], ve[i], w);
      check("throughput_no_wait", 32'(w), 32'd0);
    end
    idle();
    drain();

    // Backpressure: 8 pairs streamed, consumer not ready in cycles 4..9
    fork
      begin
        for (int i = 0; i < 8; i++) send(va[i], vb[i], ve[i], w);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_a_tready", 32'(a_ready), 32'd0);
        check("bp_b_tready", 32'(b_ready), 32'd0);
        check("bp_tvalid", 32'(m_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();
    check("bp_rx_total", 32'(n_rx), 32'd25);

    // Join: A valid alone must not transfer
    rx0     = n_rx;
    a_valid = 1'b1;
    a_data  = 32'h40000000;
    b_valid = 1'b0;
    b_data  = 32'h40400000;
    repeat (5) begin
      @(negedge clk);
      check("join_a_tready", 32'(a_ready), 32'd0);
    end
    check("join_b_tready", 32'(b_ready), 32'd1);
    check("join_no_output", 32'(n_rx - rx0), 32'd0);
    @(posedge clk);
    #1;
    send(32'h40000000, 32'h40400000, 32'h40C00000, w);
    idle();
    drain();
    check("join_one_result", 32'(n_rx - rx0), 32'd1);

    // Mid-flight reset discards in-flight pairs; a new pair right after returns in 3
    rx0 = n_rx;
    send(va[1], vb[1], ve[1], w);
    send(va[3], vb[3], ve[3], w);
    idle();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_tvalid", 32'(m_valid), 32'd0);
    check("post_rst_tdata", m_data, 32'h00000000);
    send(va[9], vb[9], ve[9], w);
    check("post_rst_accept", 32'(w), 32'd0);
    idle();
    check_latency("latency_after_rst");
    drain();
    check("rst_one_result", 32'(n_rx - rx0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fmul_axis.md
FMUL_AXIS -- requirements
Module: fmul_axis

Interface
REQ-001 Parameters: none; the format is fixed IEEE-754 binary32 and the latency is fixed at 3.
REQ-002 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-003 INITIALIZE  in  1  reset, synchronous and active-high.
REQ-004 s_axis_a_tvalid  in  1  operand A valid.
REQ-005 s_axis_a_tready  out  1  operand A accepted this cycle when high together with a_tvalid.
REQ-006 s_axis_a_tdata  in  32  operand A, binary32.
REQ-007 s_axis_b_tvalid  in  1  operand B valid.
REQ-008 s_axis_b_tready  out  1  operand B accepted this cycle when high together with b_tvalid.
REQ-009 s_axis_b_tdata  in  32  operand B, binary32.
REQ-010 m_axis_result_tvalid  out  1  product valid.
REQ-011 m_axis_result_tready  in  1  downstream accepts the product.
REQ-012 m_axis_result_tdata  out  32  product, binary32.

Function
REQ-013 The block shall be the responder for the dispatcher's multiply channel: it computes a*b on joined A/B AXI-stream inputs.
REQ-014 Join: a_tready = b_tvalid & ~stall & ~INITIALIZE and b_tready = a_tvalid & ~stall & ~INITIALIZE, so A and B transfer only in the same cycle.
REQ-015 stall shall equal m_axis_result_tvalid & ~m_axis_result_tready.
REQ-016 The pipeline has 3 stages: S1 unpack/classify, S2 24x24 mantissa multiply, S3 normalize/round/pack.
REQ-017 Latency: an accepted pair in cycle N shall give m_axis_result_tvalid=1 in cycle N+3 when no stall occurs.
REQ-018 Throughput: the block shall accept one pair per cycle while tready is held high.
REQ-019 While stall=1 all stage registers shall hold; tdata and tvalid stay stable until the handshake; no data is lost or duplicated.
REQ-020 Bubbles shall propagate as invalid stages; m_axis_result_tvalid drops when S3 is empty after a handshake.
REQ-021 Sign of every result = sign(a) XOR sign(b), including zeros and infinities; the canonical NaN in REQ-022 is the only exception.
REQ-022 Any NaN operand, or inf*zero, shall give 0x7FC00000.
REQ-023 inf times a finite nonzero operand shall give a signed infinity.
REQ-024 A zero or denormal operand is flushed to zero and shall give a signed zero, unless REQ-022 applies.
REQ-025 Exponent: e = ea + eb - 127 on 10-bit signed arithmetic; the 48-bit product is normalized by a 1-bit shift when bit 47 is set.
REQ-026 Rounding shall be round-to-nearest-even using guard and sticky bits; a mantissa carry-out increments e.
REQ-027 If e >= 255 after rounding, the result shall be a signed infinity (0x7F800000 | sign).
REQ-028 If e <= 0 after rounding, the result shall be a signed zero (no denormal output).

Reset
REQ-029 While INITIALIZE=1: all stage valids clear, both s_axis tready outputs are 0, and m_axis_result_tvalid=0 in the following cycle.
REQ-030 m_axis_result_tdata shall reset to 0x00000000.
REQ-031 INITIALIZE asserted mid-operation shall discard all in-flight operations, with no output for them after reset.
REQ-032 The block shall accept operands in the first cycle after INITIALIZE deasserts.

Verification
REQ-033 Basic products, tready=1: A=0x40000000, B=0x40400000 accepted in cycle N -> tvalid in N+3, tdata=0x40C00000. A=0x3FC00000, B=0x3FC00000 -> 0x40100000.
REQ-034 Sign and rounding: 0x3F800000 * 0xBF800000 -> 0xBF800000. 0x3F800001 * 0x3F800001 -> 0x3F800002.
REQ-035 Special values and range:
- 0x7F800000 * 0x00000000 -> 0x7FC00000.
- 0x7F000000 * 0x40000000 -> 0x7F800000.
- 0x00800000 * 0x00800000 -> 0x00000000.
- 0x80000001 * 0x3F800000 -> 0x80000000.
REQ-036 Backpressure: stream 8 pairs back-to-back with tready=0 for cycles 4..9 -> the first result is held stable, tready outputs drop to 0, and all 8 results emerge in order with none lost or duplicated.
REQ-037 Join: a_tvalid=1 with b_tvalid=0 for 5 cycles -> a_tready=0 and no result; b_tvalid then rises -> exactly one result.
REQ-038 Mid-flight reset: accept 2 pairs, pulse INITIALIZE for 1 cycle -> tvalid=0 and no stale output; a new pair accepted right after reset returns in 3 cycles.
